urna_booth_arbiter: RTL

- Round-robin scheduler that lets N voting booths share one Urna_module tally core.
- Each booth presents a complete multi-digit vote code under a Req/Ack handshake.
- The arbiter grants one booth at a time and serializes its code into the core's Digit/Valid/Finish interface with fixed, deterministic timing.
- A Close input ends the election. Sits between the booth keypads and the tally core.

---
 rtl/urna_booth_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/urna_booth_arbiter.sv
// Round-robin arbiter that lets several voting booths share one Urna tally core.
// The granted booth's code is latched, then sent to the core one nibble at a time.
module urna_booth_arbiter #(
    parameter int N_BOOTHS = 4,
    parameter int DIGITS   = 4,
    parameter int GAP      = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_BOOTHS-1:0]          req_i,
    input  logic [N_BOOTHS*4*DIGITS-1:0] voteCode_i,
    input  logic                         close_i,
    output logic [N_BOOTHS-1:0]          grant_o,
    output logic [N_BOOTHS-1:0]          ack_o,
    output logic [3:0]                   digit_o,
    output logic                         valid_o,
    output logic                         finish_o,
    output logic                         busy_o,
    output logic                         closed_o,
    output logic [15:0]                  votesServed_o
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(N_BOOTHS);
    localparam int IW = $clog2(DIGITS + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_FINISH,
        S_ACK,
        S_CLOSED
    } state_t;

    state_t              state_q;
    logic [N_BOOTHS-1:0] grant_q;
    logic [N_BOOTHS-1:0] ack_q;
    logic [3:0]          digit_q;
    logic                valid_q;
    logic                finish_q;
    logic                busy_q;
    logic                closed_q;
    logic [15:0]         votesServed_q;
    logic [PW-1:0]       ptr_q;
    logic [W-1:0]        shift_q;
    logic [W-1:0]        shift_d;
    logic [IW-1:0]       digitIdx_q;
    logic [GW-1:0]       gapCnt_q;
    logic                closeSeen_q;

    logic                pickValid;
    logic [PW-1:0]       pickIdx;
    logic [W-1:0]        pickCode;

    // Scan from the farthest booth back toward ptr+1 so the nearest requester wins.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int k = N_BOOTHS; k >= 1; k--) begin
            if (req_i[(int'(ptr_q) + k) % N_BOOTHS]) begin
                pickValid = 1'b1;
                pickIdx   = PW'((int'(ptr_q) + k) % N_BOOTHS);
            end
        end
    end

    assign pickCode = voteCode_i[int'(pickIdx)*W +: W];
    assign shift_d  = shift_q << 4;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            ack_q         <= '0;
            digit_q       <= '0;
            valid_q       <= 1'b0;
            finish_q      <= 1'b0;
            busy_q        <= 1'b0;
            closed_q      <= 1'b0;
            votesServed_q <= '0;
            ptr_q         <= PW'(N_BOOTHS - 1);
            shift_q       <= '0;
            digitIdx_q    <= '0;
            gapCnt_q      <= '0;
            closeSeen_q   <= 1'b0;
        end else begin
            ack_q <= '0;
            if (busy_q && close_i) begin
                closeSeen_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (close_i) begin
                        state_q  <= S_CLOSED;
                        closed_q <= 1'b1;
                    end else if (pickValid) begin
                        state_q     <= S_SETUP;
                        grant_q     <= {{(N_BOOTHS-1){1'b0}}, 1'b1} << pickIdx;
                        ptr_q       <= pickIdx;
                        shift_q     <= pickCode;
                        digit_q     <= pickCode[W-1 -: 4];
                        digitIdx_q  <= '0;
                        busy_q      <= 1'b1;
                        closeSeen_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    state_q <= S_STROBE;
                    valid_q <= 1'b1;
                end
                S_STROBE: begin
                    state_q  <= S_GAP;
                    valid_q  <= 1'b0;
                    gapCnt_q <= '0;
                end
                S_GAP: begin
                    if (int'(gapCnt_q) == GAP - 1) begin
                        if (int'(digitIdx_q) == DIGITS - 1) begin
                            state_q  <= S_FINISH;
                            finish_q <= 1'b1;
                            digit_q  <= '0;
                        end else begin
                            state_q    <= S_SETUP;
                            digitIdx_q <= digitIdx_q + 1'b1;
                            shift_q    <= shift_d;
                            digit_q    <= shift_d[W-1 -: 4];
                        end
                    end else begin
                        gapCnt_q <= gapCnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q  <= S_ACK;
                    finish_q <= 1'b0;
                    ack_q    <= grant_q;
                    grant_q  <= '0;
                    if (votesServed_q != 16'hFFFF) begin
                        votesServed_q <= votesServed_q + 16'd1;
                    end
                end
                S_ACK: begin
                    busy_q <= 1'b0;
                    // A close seen anywhere during service ends the election once this vote is acked.
                    if (closeSeen_q || close_i) begin
                        state_q  <= S_CLOSED;
                        closed_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CLOSED: begin
                    state_q <= S_CLOSED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign ack_o         = ack_q;
    assign digit_o       = digit_q;
    assign valid_o       = valid_q;
    assign finish_o      = finish_q;
    assign busy_o        = busy_q;
    assign closed_o      = closed_q;
    assign votesServed_o = votesServed_q;

endmodule
